// File: rtl/reg_status_file_if.sv
// reg_status_file_if
//    Decoder/ROB-facing bus of the architectural register/status file.
//    master : the pipeline side (ROB commit port, decoder rename and query)
//    slave  : the register/status file itself
//    Signals
//       commit_rob_tag/commit_reg/commit_value : committed result, tag 0 = idle
//       rename_tag/rename_reg                  : destination rename, tag 0 = idle
//       flush                                  : mispredict, clears every rename tag
//       query_reg1/2 -> out_value1/2,out_tag1/2: combinational operand lookup
//       busy_count                             : registers holding a nonzero tag
interface reg_status_file_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int ROB_W  = 5
);
   logic [ROB_W-1:0]  commit_rob_tag;
   logic [REG_W-1:0]  commit_reg;
   logic [DATA_W-1:0] commit_value;
   logic [ROB_W-1:0]  rename_tag;
   logic [REG_W-1:0]  rename_reg;
   logic              flush;
   logic [REG_W-1:0]  query_reg1;
   logic [REG_W-1:0]  query_reg2;
   logic [DATA_W-1:0] out_value1;
   logic [DATA_W-1:0] out_value2;
   logic [ROB_W-1:0]  out_tag1;
   logic [ROB_W-1:0]  out_tag2;
   logic [REG_W:0]    busy_count;

   modport master (
      output commit_rob_tag, commit_reg, commit_value,
      output rename_tag, rename_reg, flush,
      output query_reg1, query_reg2,
      input  out_value1, out_value2, out_tag1, out_tag2, busy_count
   );

   modport slave (
      input  commit_rob_tag, commit_reg, commit_value,
      input  rename_tag, rename_reg, flush,
      input  query_reg1, query_reg2,
      output out_value1, out_value2, out_tag1, out_tag2, busy_count
   );
endinterface

// File: rtl/reg_status_file.sv
// reg_status_file
//    Committed architectural register values plus, per register, the ROB tag
//    of the youngest in-flight producer. x0 reads as (0, 0) and ignores writes.
//    Ports
//       clk  : clock, all state updates on posedge
//       rst  : asynchronous active-high reset, clears values, tags and busy_count
//       bus  : reg_status_file_if.slave (commit, rename, flush, two query ports,
//              busy_count)
module reg_status_file #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int ROB_W  = 5
) (
   input logic              clk,
   input logic              rst,
   reg_status_file_if.slave bus
);
   localparam int NUM_REGS = 2 ** REG_W;
   localparam logic [REG_W:0] CNT_ONE = {{REG_W{1'b0}}, 1'b1};

   logic [DATA_W-1:0] value_q [NUM_REGS];
   logic [DATA_W-1:0] value_d [NUM_REGS];
   logic [ROB_W-1:0]  tag_q   [NUM_REGS];
   logic [ROB_W-1:0]  tag_d   [NUM_REGS];
   logic [REG_W:0]    busy_count_q;
   logic [REG_W:0]    busy_count_d;

   logic commit_act;
   logic commit_clr;
   logic rename_act;
   logic rename_was_free;

   logic [DATA_W-1:0] out_value1;
   logic [DATA_W-1:0] out_value2;
   logic [ROB_W-1:0]  out_tag1;
   logic [ROB_W-1:0]  out_tag2;

   always_comb begin
      commit_act      = (bus.commit_rob_tag != '0) && (bus.commit_reg != '0);
      // A commit only retires the tag if it is still the youngest producer.
      commit_clr      = commit_act && (tag_q[bus.commit_reg] == bus.commit_rob_tag);
      rename_act      = (bus.rename_tag != '0) && (bus.rename_reg != '0) && !bus.flush;
      rename_was_free = (tag_q[bus.rename_reg] == '0);
   end

   always_comb begin
      value_d = value_q;
      tag_d   = tag_q;
      if (commit_act) begin
         value_d[bus.commit_reg] = bus.commit_value;
      end
      if (commit_clr) begin
         tag_d[bus.commit_reg] = '0;
      end
      // Rename after clear: a same-register rename leaves the new tag pending.
      if (rename_act) begin
         tag_d[bus.rename_reg] = bus.rename_tag;
      end
      if (bus.flush) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            tag_d[i] = '0;
         end
      end
      value_d[0] = '0;
      tag_d[0]   = '0;
   end

   always_comb begin
      busy_count_d = busy_count_q;
      if (bus.flush) begin
         busy_count_d = '0;
      end else if (!(rename_act && commit_clr && (bus.rename_reg == bus.commit_reg))) begin
         if (rename_act && rename_was_free) begin
            busy_count_d = busy_count_d + CNT_ONE;
         end
         if (commit_clr) begin
            busy_count_d = busy_count_d - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
         busy_count_q <= '0;
      end else begin
         value_q      <= value_d;
         tag_q        <= tag_d;
         busy_count_q <= busy_count_d;
      end
   end

   // Queries see pre-edge state plus the same-cycle retiring commit; never
   // the same-cycle rename or flush.
   always_comb begin
      out_value1 = '0;
      out_tag1   = '0;
      if (bus.query_reg1 != '0) begin
         if (commit_clr && (bus.commit_reg == bus.query_reg1)) begin
            out_value1 = bus.commit_value;
         end else begin
            out_value1 = value_q[bus.query_reg1];
            out_tag1   = tag_q[bus.query_reg1];
         end
      end
   end

   always_comb begin
      out_value2 = '0;
      out_tag2   = '0;
      if (bus.query_reg2 != '0) begin
         if (commit_clr && (bus.commit_reg == bus.query_reg2)) begin
            out_value2 = bus.commit_value;
         end else begin
            out_value2 = value_q[bus.query_reg2];
            out_tag2   = tag_q[bus.query_reg2];
         end
      end
   end

   assign bus.out_value1 = out_value1;
   assign bus.out_value2 = out_value2;
   assign bus.out_tag1   = out_tag1;
   assign bus.out_tag2   = out_tag2;
   assign bus.busy_count = busy_count_q;
endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file
//    Directed scenarios followed by randomized traffic, checked against a
//    register-array reference model whose busy count is a plain tally of
//    nonzero tags.
module tb_reg_status_file;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   reg_status_file_if #(.DATA_W(32), .REG_W(5), .ROB_W(5)) bus ();

   reg_status_file #(.DATA_W(32), .REG_W(5), .ROB_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] m_val [32];
   logic [4:0]  m_tag [32];

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%08h expected=%08h", name, obs, exp);
      end
   endtask

   function automatic int model_busy();
      int n = 0;
      for (int i = 1; i < 32; i++) if (m_tag[i] != 0) n++;
      return n;
   endfunction

   function automatic logic [36:0] model_query(input logic [4:0] q);
      if (q == 0) return '0;
      if (bus.commit_rob_tag != 0 && bus.commit_reg == q && m_tag[q] == bus.commit_rob_tag)
         return {5'd0, bus.commit_value};
      return {m_tag[q], m_val[q]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_val[i] = '0;
         m_tag[i] = '0;
      end
   endtask

   task automatic model_edge();
      logic clr;
      if (rst) return;
      clr = 1'b0;
      if (bus.commit_rob_tag != 0 && bus.commit_reg != 0) begin
         clr = (m_tag[bus.commit_reg] == bus.commit_rob_tag);
         m_val[bus.commit_reg] = bus.commit_value;
      end
      if (clr) m_tag[bus.commit_reg] = 0;
      if (bus.rename_tag != 0 && bus.rename_reg != 0 && !bus.flush)
         m_tag[bus.rename_reg] = bus.rename_tag;
      if (bus.flush) for (int i = 0; i < 32; i++) m_tag[i] = 0;
   endtask

   task automatic idle();
      bus.commit_rob_tag = '0;
      bus.commit_reg     = '0;
      bus.commit_value   = '0;
      bus.rename_tag     = '0;
      bus.rename_reg     = '0;
      bus.flush          = 1'b0;
   endtask

   task automatic set_commit(input logic [4:0] t, input logic [4:0] r, input logic [31:0] v);
      bus.commit_rob_tag = t;
      bus.commit_reg     = r;
      bus.commit_value   = v;
   endtask

   task automatic set_rename(input logic [4:0] t, input logic [4:0] r);
      bus.rename_tag = t;
      bus.rename_reg = r;
   endtask

   task automatic set_query(input logic [4:0] a, input logic [4:0] b);
      bus.query_reg1 = a;
      bus.query_reg2 = b;
   endtask

   task automatic check_q(input string tag);
      logic [36:0] e1;
      logic [36:0] e2;
      e1 = model_query(bus.query_reg1);
      e2 = model_query(bus.query_reg2);
      chk({tag, "_val1"}, bus.out_value1, e1[31:0]);
      chk({tag, "_tag1"}, {27'd0, bus.out_tag1}, {27'd0, e1[36:32]});
      chk({tag, "_val2"}, bus.out_value2, e2[31:0]);
      chk({tag, "_tag2"}, {27'd0, bus.out_tag2}, {27'd0, e2[36:32]});
   endtask

   // Inputs settle, queries are checked, clock edge, then busy_count checked.
   task automatic cycle(input string tag);
      #1;
      check_q(tag);
      @(posedge clk);
      model_edge();
      #1;
      chk({tag, "_busy"}, {26'd0, bus.busy_count}, model_busy());
   endtask

   initial begin
      logic [4:0] r;
      logic [4:0] t;
      vectors     = 0;
      miscompares = 0;
      model_reset();
      idle();
      set_query(5'd5, 5'd0);
      rst = 1'b1;
      #2;
      chk("rst_val1", bus.out_value1, 32'd0);
      chk("rst_tag1", {27'd0, bus.out_tag1}, 32'd0);
      chk("rst_val2", bus.out_value2, 32'd0);
      chk("rst_tag2", {27'd0, bus.out_tag2}, 32'd0);
      chk("rst_busy", {26'd0, bus.busy_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      set_rename(5'd4, 5'd3);
      cycle("ren_x3");
      idle();
      set_query(5'd3, 5'd3);
      #1;
      chk("x3_pending_tag", {27'd0, bus.out_tag1}, 32'd4);
      chk("x3_busy1", {26'd0, bus.busy_count}, 32'd1);
      set_commit(5'd4, 5'd3, 32'h1234);
      #1;
      chk("x3_bypass_val", bus.out_value1, 32'h1234);
      chk("x3_bypass_tag", {27'd0, bus.out_tag1}, 32'd0);
      cycle("com_x3");
      idle();
      #1;
      chk("x3_final_val", bus.out_value2, 32'h1234);
      chk("x3_busy0", {26'd0, bus.busy_count}, 32'd0);

      set_query(5'd7, 5'd0);
      set_rename(5'd2, 5'd7);
      cycle("ren_x7a");
      set_rename(5'd6, 5'd7);
      cycle("ren_x7b");
      idle();
      set_commit(5'd2, 5'd7, 32'hAA);
      cycle("com_x7_old");
      idle();
      #1;
      chk("x7_stale_val", bus.out_value1, 32'hAA);
      chk("x7_stale_tag", {27'd0, bus.out_tag1}, 32'd6);
      chk("x7_busy1", {26'd0, bus.busy_count}, 32'd1);
      set_commit(5'd6, 5'd7, 32'hBB);
      cycle("com_x7_new");
      idle();
      #1;
      chk("x7_final_val", bus.out_value1, 32'hBB);
      chk("x7_final_tag", {27'd0, bus.out_tag1}, 32'd0);

      set_query(5'd9, 5'd7);
      set_rename(5'd3, 5'd9);
      cycle("ren_x9");
      set_commit(5'd3, 5'd9, 32'h55);
      set_rename(5'd8, 5'd9);
      cycle("com_ren_x9");
      idle();
      #1;
      chk("x9_val", bus.out_value1, 32'h55);
      chk("x9_tag", {27'd0, bus.out_tag1}, 32'd8);
      chk("x9_busy1", {26'd0, bus.busy_count}, 32'd1);

      for (int i = 1; i <= 4; i++) begin
         set_rename(5'(i), 5'(i));
         cycle("ren_x1_4");
      end
      idle();
      bus.flush = 1'b1;
      set_rename(5'd5, 5'd5);
      set_commit(5'd2, 5'd2, 32'h77);
      set_query(5'd2, 5'd4);
      cycle("flush");
      idle();
      set_query(5'd2, 5'd5);
      #1;
      chk("flush_x2_val", bus.out_value1, 32'h77);
      chk("flush_x2_tag", {27'd0, bus.out_tag1}, 32'd0);
      chk("flush_x5_tag", {27'd0, bus.out_tag2}, 32'd0);
      chk("flush_busy0", {26'd0, bus.busy_count}, 32'd0);

      set_rename(5'd7, 5'd0);
      set_commit(5'd7, 5'd0, 32'hFFFF_FFFF);
      set_query(5'd0, 5'd0);
      cycle("x0_write");
      idle();
      #1;
      chk("x0_val", bus.out_value1, 32'd0);
      chk("x0_busy", {26'd0, bus.busy_count}, 32'd0);

      for (int n = 0; n < 400; n++) begin
         idle();
         r = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) != 0 && m_tag[r] != 0) t = m_tag[r];
         else t = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 2) != 0) set_commit(t, r, $urandom);
         if ($urandom_range(0, 1) != 0)
            set_rename(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         bus.flush = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 1) != 0) set_query(r, 5'($urandom_range(0, 31)));
         else set_query(5'($urandom_range(0, 31)), bus.rename_reg);
         cycle("rand");
      end

      idle();
      for (int i = 1; i <= 6; i++) begin
         set_rename(5'(i + 10), 5'(i));
         cycle("pre_rst");
      end
      set_commit(5'd11, 5'd1, 32'hDEAD_BEEF);
      set_rename(5'd20, 5'd9);
      set_query(5'd1, 5'd2);
      rst = 1'b1;
      model_reset();
      #1;
      chk("midrst_val1", bus.out_value1, 32'd0);
      chk("midrst_tag1", {27'd0, bus.out_tag1}, 32'd0);
      chk("midrst_tag2", {27'd0, bus.out_tag2}, 32'd0);
      chk("midrst_busy", {26'd0, bus.busy_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      set_query(5'd9, 5'd1);
      cycle("post_rst");
      chk("post_rst_x9_tag", {27'd0, bus.out_tag1}, 32'd0);
      chk("post_rst_x1_val", bus.out_value2, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
